// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: depth derivation,
// threshold defaults, parameter legality and the per-cycle access struct.
package fifo_pkg;

    localparam int ASIZE_DEF     = 4;
    localparam int DSIZE_DEF     = 8;
    localparam int AEMPTY_TH_DEF = 2;

    // Accepted operations for one cycle, judged on pre-edge state.
    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_acc_t;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic int afull_th_def(input int asize);
        return fifo_depth(asize) - 2;
    endfunction

    // ASIZE is capped so DEPTH and the pointer arithmetic stay within 32 bits.
    function automatic bit fifo_params_ok(input int dsize, input int asize,
                                          input int afull_th, input int aempty_th);
        bit ok;
        ok = 1'b1;
        if (dsize < 1) ok = 1'b0;
        if (asize < 1 || asize > 30) ok = 1'b0;
        if (afull_th < 1 || afull_th > fifo_depth(asize)) ok = 1'b0;
        if (aempty_th < 0 || aempty_th >= fifo_depth(asize)) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE storage with one write port and one read port; the read port
// is combinational in fall-through mode and a read-enabled register otherwise.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    // Storage is deliberately not reset; the pointers define what is valid.
    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic unused_rd_ctl;
            assign unused_rd_ctl = &{1'b0, re, rst_n};
            assign rdata = mem[raddr];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdata <= '0;
                else if (re) rdata <= mem[raddr];
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary wrap-bit pointers, occupancy/flag decode straight
// from the pointer registers, sticky overflow/underflow, selectable read mode.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ASIZE     = ASIZE_DEF,
    parameter int AFULL_TH  = afull_th_def(ASIZE),
    parameter int AEMPTY_TH = AEMPTY_TH_DEF,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = fifo_depth(ASIZE);
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] PTR_ONE  = (ASIZE+1)'(1);

    generate
        if (!fifo_params_ok(DSIZE, ASIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
            $error("sync_fifo: illegal DSIZE/ASIZE/AFULL_TH/AEMPTY_TH combination");
        end
    endgenerate

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    fifo_acc_t      acc;

    // Modulo subtraction of wrap-bit pointers gives 0..DEPTH across any number of wraps.
    assign count        = wptr - rptr;
    assign wfull        = (count == FULL_CNT);
    assign rempty       = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    always_comb begin
        acc    = '0;
        acc.wr = winc && !wfull;
        acc.rd = rinc && !rempty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (acc.wr) wptr <= wptr + PTR_ONE;
            if (acc.rd) rptr <= rptr + PTR_ONE;
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .FWFT  (FWFT)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (acc.wr),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .re    (acc.rd),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a standard-read and a fall-through FIFO with the same stimulus and
// checks both every cycle against a queue-based model of the FIFO rules.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] rd_s, rd_f;
    logic [AW:0]   cnt_s, cnt_f;
    logic wf_s, wf_f, re_s, re_f, af_s, af_f, ae_s, ae_f, ov_s, ov_f, un_s, un_f;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(DW), .ASIZE(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rd_s),
        .wfull(wf_s), .rempty(re_s), .almost_full(af_s), .almost_empty(ae_s),
        .count(cnt_s), .overflow(ov_s), .underflow(un_s));

    sync_fifo #(.DSIZE(DW), .ASIZE(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rd_f),
        .wfull(wf_f), .rempty(re_f), .almost_full(af_f), .almost_empty(ae_f),
        .count(cnt_f), .overflow(ov_f), .underflow(un_f));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: contents queue, sticky error bits, last popped word.
    logic [DW-1:0] q[$];
    bit            m_ov, m_un;
    logic [DW-1:0] m_rd;
    bit            m_wok, m_rok;
    bit            chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_rd = '0;
        end else begin
            m_wok = winc && (q.size() < DEPTH);
            m_rok = rinc && (q.size() > 0);
            if (winc && !m_wok) m_ov = 1'b1;
            if (rinc && !m_rok) m_un = 1'b1;
            if (m_rok) m_rd = q.pop_front();
            if (m_wok) q.push_back(wdata);
        end
    end

    task automatic cmp_dut(input string nm, input logic [AW:0] c, input logic wf, input logic re,
                           input logic af, input logic ae, input logic ov, input logic un);
        int n;
        n = q.size();
        chk({nm, ".count"}, 32'(c), n);
        chk({nm, ".wfull"}, 32'(wf), 32'(n == DEPTH));
        chk({nm, ".rempty"}, 32'(re), 32'(n == 0));
        chk({nm, ".almost_full"}, 32'(af), 32'(n >= AF));
        chk({nm, ".almost_empty"}, 32'(ae), 32'(n <= AE));
        chk({nm, ".overflow"}, 32'(ov), 32'(m_ov));
        chk({nm, ".underflow"}, 32'(un), 32'(m_un));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("std", cnt_s, wf_s, re_s, af_s, ae_s, ov_s, un_s);
            cmp_dut("fwft", cnt_f, wf_f, re_f, af_f, ae_f, ov_f, un_f);
            chk("std.rdata", 32'(rd_s), 32'(m_rd));
            if (q.size() > 0) chk("fwft.rdata", 32'(rd_f), 32'(q[0]));
        end
    end

    // Inputs change at the falling edge and are sampled by the next rising edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge clk);
        @(negedge clk);
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        chk("rst.rempty", 32'(re_s), 1);
        chk("rst.wfull", 32'(wf_s), 0);
        chk("rst.count", 32'(cnt_s), 0);
        chk("rst.almost_empty", 32'(ae_s), 1);
        chk("rst.almost_full", 32'(af_s), 0);
        chk("rst.overflow", 32'(ov_s), 0);
        chk("rst.underflow", 32'(un_s), 0);
        chk("rst.rdata", 32'(rd_s), 0);

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 1)  chk("fill.ae_after2", 32'(ae_s), 1);
            if (i == 2)  chk("fill.ae_after3", 32'(ae_s), 0);
            if (i == 12) chk("fill.af_after13", 32'(af_s), 0);
            if (i == 13) chk("fill.af_after14", 32'(af_s), 1);
            if (i == 14) chk("fill.wfull_after15", 32'(wf_s), 0);
        end
        chk("fill.wfull", 32'(wf_s), 1);
        chk("fill.count", 32'(cnt_s), 16);
        chk("fill.fwft_head", 32'(rd_f), 8'h00);

        step(1'b1, 8'hAA, 1'b0);
        chk("ovf.flag", 32'(ov_s), 1);
        chk("ovf.count", 32'(cnt_s), 16);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain.rdata", 32'(rd_s), i);
        end

        step(1'b0, 8'h00, 1'b1);
        chk("unf.flag", 32'(un_s), 1);
        chk("unf.count", 32'(cnt_s), 0);
        chk("unf.rdata_held", 32'(rd_s), 8'h0F);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'h20, 1'b1);
        chk("rw5.count", 32'(cnt_s), 5);
        chk("rw5.rdata", 32'(rd_s), 8'h10);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        chk("rw5.last", 32'(rd_s), 8'h20);

        step(1'b1, 8'h33, 1'b1);
        chk("rw0.count", 32'(cnt_s), 1);
        chk("rw0.underflow", 32'(un_s), 1);
        chk("rw0.fwft_head", 32'(rd_f), 8'h33);

        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        chk("rw16.count", 32'(cnt_s), 15);
        chk("rw16.overflow", 32'(ov_s), 1);
        chk("rw16.rdata", 32'(rd_s), 8'h40);
        chk("rw16.underflow", 32'(un_s), 0);

        do_reset();
        step(1'b1, 8'h5A, 1'b0);
        chk("mode.fwft_fallthrough", 32'(rd_f), 8'h5A);
        chk("mode.std_before_read", 32'(rd_s), 8'h00);
        step(1'b0, 8'h00, 1'b0);
        chk("mode.std_idle", 32'(rd_s), 8'h00);
        step(1'b0, 8'h00, 1'b1);
        chk("mode.std_after_read", 32'(rd_s), 8'h5A);

        // Random phases: write-heavy, read-heavy, balanced; many pointer wraps.
        do_reset();
        for (int i = 0; i < 450; i++) begin
            logic w, r;
            if (i < 100) begin
                w = 1'($urandom_range(0, 3) != 0);
                r = 1'($urandom_range(0, 3) == 0);
            end else if (i < 200) begin
                w = 1'($urandom_range(0, 3) == 0);
                r = 1'($urandom_range(0, 3) != 0);
            end else begin
                w = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end
            step(w, 8'($urandom), r);
        end

        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        chk("mid.count_before", 32'(cnt_s), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.count", 32'(cnt_s), 0);
        chk("mid.rempty", 32'(re_s), 1);
        chk("mid.wfull", 32'(wf_s), 0);
        chk("mid.almost_empty", 32'(ae_s), 1);
        chk("mid.almost_full", 32'(af_s), 0);
        chk("mid.rdata", 32'(rd_s), 0);
        chk("mid.fwft_count", 32'(cnt_f), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 8'hC3, 1'b0);
        chk("mid.after_count", 32'(cnt_s), 1);
        chk("mid.after_fwft", 32'(rd_f), 8'hC3);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
